decodificador_secded_param: RTL and testbench
=============================================

Name: decodificador_secded_param

Overview:
Parametrised, pipelined successor to the combinational Hamming encode/compare/correct chain. It accepts an extended-Hamming (SECDED) codeword through a valid/ready handshake, computes the syndrome and overall parity, and corrects single-bit errors. It detects double-bit errors, and saturating counters keep error statistics. It sits between the received-word source (switches or upstream link) and the display/consumer logic.

Parameters:
DATA_W, 4, number of data bits k (minimum 1).
PAR_W, derived localparam, smallest p with 2^p >= DATA_W + p + 1 (DATA_W=4 gives 3).
N, derived localparam, codeword width DATA_W + PAR_W + 1 (DATA_W=4 gives 8).
POS_W, derived localparam, clog2(N), the width of the error position.
CNT_W, 8, width of each error counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
palabra_in  input  N  received codeword
valid_in  input  1  palabra_in is valid
ready_in  output  1  block can accept a word this cycle
en_correccion  input  1  1: correct single errors; 0: detect only, data passes uncorrected
clr_cnt  input  1  synchronous clear of both counters
data_out  output  DATA_W  decoded data bits
valid_out  output  1  output word valid
ready_out  input  1  consumer accepts output word
err_simple  output  1  single error detected for the current output word
err_doble  output  1  uncorrectable error detected for the current output word
pos_error  output  POS_W  codeword bit index of the single error (0 when none)
cnt_corr  output  CNT_W  count of accepted words with err_simple=1
cnt_nocorr  output  CNT_W  count of accepted words with err_doble=1

Behaviour:
- Codeword layout: bit 0 is the overall parity, which makes the full word even parity. Bits 1..N-1 are Hamming positions equal to their index. Indices that are powers of two hold parity bits. The remaining indices hold data bits, with DATA_W bit 0 at the lowest index.
- Stage 1 registers the syndrome s (PAR_W bits, XOR of the indices of all set bits in 1..N-1), the overall parity q (XOR of all N bits), and the raw word.
- Stage 2 registers the classification, the corrected word, the extracted data, and the flags.
- Classification:
  - s=0, q=0: no error.
  - s=0, q=1: single error in bit 0. err_simple=1, pos_error=0, data unchanged.
  - s!=0, q=1, s<=N-1: single error at index s. err_simple=1, pos_error=s. If en_correccion=1, bit s is flipped before data extraction.
  - s!=0, q=0: err_doble=1, pos_error=0, data is the raw extraction.
  - s!=0, q=1, s>N-1 (shortened codes): err_doble=1.
- err_simple and err_doble are never both 1.
- en_correccion is sampled with the word in stage 1 and travels with it.
- Flow control: avanza = !valid_out || ready_out. ready_in = avanza. Both stages advance only when avanza=1.
- A word is accepted when valid_in && ready_in.
- Latency: exactly 2 cycles from acceptance to valid_out when ready_out is held high. Throughput is 1 word/cycle.
- Stall: when valid_out=1 and ready_out=0, all outputs and stage registers hold, and ready_in=0.
- Bubbles: valid_in=0 while advancing inserts an invalid slot. Counters never change on invalid slots.
- Counters: each increments by 1 on an output handshake (valid_out && ready_out) whose flag is set. Each saturates at 2^CNT_W-1 and never wraps.
- clr_cnt=1 zeroes both counters the next cycle and wins over a simultaneous increment.
- Reset, including mid-stream: valid_out=0, both stage valids=0, data_out=0, err_simple=0, err_doble=0, pos_error=0, cnt_corr=0, cnt_nocorr=0. In-flight words are discarded. ready_in=1 from the first cycle after reset.

Test Plan:
1. Clean word: DATA_W=4, palabra_in=8'hAA (data 4'b1011), ready_out=1 -> 2 cycles later valid_out=1, data_out=4'b1011, err_simple=0, err_doble=0, pos_error=0; counters unchanged.
2. Single data-bit error: palabra_in=8'h8A (bit 5 flipped), en_correccion=1 -> data_out=4'b1011, err_simple=1, pos_error=5, cnt_corr=1. Same word with en_correccion=0 -> data_out=4'b1001, err_simple=1, pos_error=5.
3. Overall-parity bit error: palabra_in=8'hAB -> data_out=4'b1011, err_simple=1, pos_error=0, cnt_corr increments.
4. Double error: palabra_in=8'h82 (bits 5 and 3) -> err_doble=1, err_simple=0, pos_error=0, cnt_nocorr increments.
5. Backpressure:
   - Stream 8'hAA, 8'h8A, 8'h82 back-to-back with ready_out=0 for 3 cycles after the first valid_out.
   - valid_out and data_out hold and ready_in=0 during the stall.
   - On release, the three words emerge in order with no loss or duplication, and each counter increments once.
6. Saturation, clear, and reset:
   - With CNT_W=2, send five 8'h8A -> cnt_corr stops at 3.
   - Assert clr_cnt coincident with a counted handshake -> cnt_corr=0.
   - Assert rst with two words in flight -> valid_out=0 next cycle and neither word ever appears.

Source files
------------

// File: rtl/decodificador_secded_param.sv
//-----------------------------------------------------------------------------
// decodificador_secded_param
//
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready flow
// control and saturating error statistics.
//
// Codeword layout: bit 0 is the overall (even) parity bit. Bits 1..N-1 are
// Hamming positions equal to their index. Power-of-two indices carry the check
// bits, and the other indices carry data (data bit 0 at the lowest index).
//
// Ports:
//   clk           rising-edge system clock
//   rst           synchronous active-high reset
//   palabra_in    received codeword (N bits)
//   valid_in      palabra_in is valid
//   ready_in      block can accept a word this cycle
//   en_correccion 1: correct single errors, 0: detect only
//   clr_cnt       synchronous clear of both error counters
//   data_out      decoded data bits (DATA_W)
//   valid_out     output word valid
//   ready_out     consumer accepts the output word
//   err_simple    single (correctable) error on the current output word
//   err_doble     uncorrectable error on the current output word
//   pos_error     codeword index of the single error (0 when none)
//   cnt_corr      accepted output words flagged err_simple (saturating)
//   cnt_nocorr    accepted output words flagged err_doble (saturating)
//-----------------------------------------------------------------------------

package decodificador_secded_param_pkg;

  // Smallest p such that 2^p >= data_w + p + 1.
  function automatic int calc_par_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < (data_w + p + 1)) begin
      p = p + 1;
    end
    return p;
  endfunction

endpackage

module decodificador_secded_param
  import decodificador_secded_param_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int N      = DATA_W + PAR_W + 1,
  localparam int POS_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      palabra_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              en_correccion,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              err_simple,
  output logic              err_doble,
  output logic [POS_W-1:0]  pos_error,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_nocorr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     BIT0    = {{(N-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // ECC helper functions
  // ---------------------------------------------------------------------------

  // XOR of the indices of every set bit in positions 1..N-1.
  function automatic logic [PAR_W-1:0] calc_syndrome(input logic [N-1:0] w);
    logic [PAR_W-1:0] s;
    s = {PAR_W{1'b0}};
    for (int i = 1; i < N; i++) begin
      if (w[i]) begin
        s = s ^ PAR_W'(i);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Even-parity check over the whole codeword: 1 means odd weight.
  function automatic logic calc_parity(input logic [N-1:0] w);
    return ^w;
  endfunction

  // Collect the non-power-of-two positions into the data word. Each data bit
  // is shifted in from the top, so the lowest index lands on data bit 0 once
  // all DATA_W bits have been pushed.
  function automatic logic [DATA_W-1:0] extract_data(input logic [N-1:0] w);
    logic [DATA_W-1:0] d;
    logic [DATA_W:0]   tmp;
    d = {DATA_W{1'b0}};
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        tmp = {w[i], d};
        d   = tmp[DATA_W:1];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Flow control: both stages move together whenever the output slot is free
  // or being consumed.
  // ---------------------------------------------------------------------------
  logic avanza_s;
  logic handshake_out_s;

  assign avanza_s        = !valid_out || ready_out;
  assign ready_in        = avanza_s;
  assign handshake_out_s = valid_out && ready_out;

  // ---------------------------------------------------------------------------
  // Stage 1: syndrome, overall parity, raw word and correction enable
  // ---------------------------------------------------------------------------
  logic             s1_valid_r;
  logic [N-1:0]     s1_word_r;
  logic [PAR_W-1:0] s1_syn_r;
  logic             s1_q_r;
  logic             s1_en_r;

  // Stage-1 register: capture the incoming slot (word or bubble) on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_word_r  <= {N{1'b0}};
      s1_syn_r   <= {PAR_W{1'b0}};
      s1_q_r     <= 1'b0;
      s1_en_r    <= 1'b0;
    end else if (avanza_s) begin
      s1_valid_r <= valid_in;
      s1_word_r  <= palabra_in;
      s1_syn_r   <= calc_syndrome(palabra_in);
      s1_q_r     <= calc_parity(palabra_in);
      s1_en_r    <= en_correccion;
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_word_r  <= s1_word_r;
      s1_syn_r   <= s1_syn_r;
      s1_q_r     <= s1_q_r;
      s1_en_r    <= s1_en_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Classification and correction (combinational, feeds stage 2)
  // ---------------------------------------------------------------------------
  logic              syn_nz_s;
  logic              syn_in_range_s;
  logic              simple_s;
  logic              doble_s;
  logic [POS_W-1:0]  pos_s;
  logic [N-1:0]      fixed_word_s;
  logic [DATA_W-1:0] data_s;

  assign syn_nz_s       = (s1_syn_r != {PAR_W{1'b0}});
  // A syndrome past the last real index can only come from a multi-bit error
  // in a shortened code.
  assign syn_in_range_s = ({1'b0, s1_syn_r} < (PAR_W + 1)'(N));

  // Decode {syndrome != 0, overall parity} into the error class and fix mask.
  always_comb begin
    simple_s     = 1'b0;
    doble_s      = 1'b0;
    pos_s        = {POS_W{1'b0}};
    fixed_word_s = s1_word_r;
    case ({syn_nz_s, s1_q_r})
      2'b00: begin
        simple_s = 1'b0;
      end
      2'b01: begin
        // Only the overall parity bit is wrong; data positions are intact.
        simple_s = 1'b1;
      end
      2'b11: begin
        if (syn_in_range_s) begin
          simple_s = 1'b1;
          pos_s    = POS_W'(s1_syn_r);
          if (s1_en_r) begin
            fixed_word_s = s1_word_r ^ (BIT0 << s1_syn_r);
          end else begin
            fixed_word_s = s1_word_r;
          end
        end else begin
          doble_s = 1'b1;
        end
      end
      2'b10: begin
        doble_s = 1'b1;
      end
      default: begin
        simple_s = 1'b0;
        doble_s  = 1'b0;
      end
    endcase
    data_s = extract_data(fixed_word_s);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs
  // ---------------------------------------------------------------------------

  // Output register: load the classified word on advance, hold during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      data_out   <= {DATA_W{1'b0}};
      err_simple <= 1'b0;
      err_doble  <= 1'b0;
      pos_error  <= {POS_W{1'b0}};
    end else if (avanza_s) begin
      valid_out  <= s1_valid_r;
      data_out   <= data_s;
      // Flags are forced low on bubbles so nothing downstream sees stale errors.
      err_simple <= simple_s && s1_valid_r;
      err_doble  <= doble_s && s1_valid_r;
      pos_error  <= s1_valid_r ? pos_s : {POS_W{1'b0}};
    end else begin
      valid_out  <= valid_out;
      data_out   <= data_out;
      err_simple <= err_simple;
      err_doble  <= err_doble;
      pos_error  <= pos_error;
    end
  end

  // ---------------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------------

  // Corrected-error counter: clear has priority, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_corr <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      cnt_corr <= {CNT_W{1'b0}};
    end else if (handshake_out_s && err_simple && (cnt_corr != CNT_MAX)) begin
      cnt_corr <= cnt_corr + CNT_ONE;
    end else begin
      cnt_corr <= cnt_corr;
    end
  end

  // Uncorrectable-error counter: clear has priority, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_nocorr <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      cnt_nocorr <= {CNT_W{1'b0}};
    end else if (handshake_out_s && err_doble && (cnt_nocorr != CNT_MAX)) begin
      cnt_nocorr <= cnt_nocorr + CNT_ONE;
    end else begin
      cnt_nocorr <= cnt_nocorr;
    end
  end

endmodule

// File: tb/tb_decodificador_secded_param.sv
//-----------------------------------------------------------------------------
// Testbench for decodificador_secded_param (DATA_W=4, N=8).
// A main instance (CNT_W=8) and a second instance with CNT_W=2 share the same
// stimulus; the second one is only inspected in the saturation sequence.
//-----------------------------------------------------------------------------
module tb_decodificador_secded_param;

  logic       clk;
  logic       rst;
  logic [7:0] palabra_in;
  logic       valid_in;
  logic       en_correccion;
  logic       clr_cnt;
  logic       ready_out;

  logic       ready_in;
  logic [3:0] data_out;
  logic       valid_out;
  logic       err_simple;
  logic       err_doble;
  logic [2:0] pos_error;
  logic [7:0] cnt_corr;
  logic [7:0] cnt_nocorr;

  logic       sat_ready_in;
  logic [3:0] sat_data_out;
  logic       sat_valid_out;
  logic       sat_err_simple;
  logic       sat_err_doble;
  logic [2:0] sat_pos_error;
  logic [1:0] sat_cnt_corr;
  logic [1:0] sat_cnt_nocorr;

  int checks;
  int failures;
  int exp_corr;
  int exp_nocorr;

  decodificador_secded_param #(.DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .palabra_in(palabra_in), .valid_in(valid_in),
    .ready_in(ready_in), .en_correccion(en_correccion), .clr_cnt(clr_cnt),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .err_simple(err_simple), .err_doble(err_doble), .pos_error(pos_error),
    .cnt_corr(cnt_corr), .cnt_nocorr(cnt_nocorr)
  );

  decodificador_secded_param #(.DATA_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .palabra_in(palabra_in), .valid_in(valid_in),
    .ready_in(sat_ready_in), .en_correccion(en_correccion), .clr_cnt(clr_cnt),
    .data_out(sat_data_out), .valid_out(sat_valid_out), .ready_out(ready_out),
    .err_simple(sat_err_simple), .err_doble(sat_err_doble),
    .pos_error(sat_pos_error), .cnt_corr(sat_cnt_corr),
    .cnt_nocorr(sat_cnt_nocorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       en;
    logic [3:0] d;
    logic       simple;
    logic       doble;
    logic [2:0] pos;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  logic [3:0] rx_d[3];
  logic       rx_s[3];
  logic       rx_dd[3];
  int         rx_n;
  int         seen;

  initial begin
    checks = 0;
    failures = 0;
    exp_corr = 0;
    exp_nocorr = 0;

    //           word    en    data     simple doble pos
    vecs[0]  = '{8'hAA, 1'b1, 4'b1011, 1'b0, 1'b0, 3'd0}; // clean
    vecs[1]  = '{8'h8A, 1'b1, 4'b1011, 1'b1, 1'b0, 3'd5}; // bit 5, corrected
    vecs[2]  = '{8'h8A, 1'b0, 4'b1001, 1'b1, 1'b0, 3'd5}; // bit 5, detect only
    vecs[3]  = '{8'hAB, 1'b1, 4'b1011, 1'b1, 1'b0, 3'd0}; // overall parity bit
    vecs[4]  = '{8'h82, 1'b1, 4'b1000, 1'b0, 1'b1, 3'd0}; // bits 5 and 3
    vecs[5]  = '{8'hA8, 1'b1, 4'b1011, 1'b1, 1'b0, 3'd1}; // check bit 1
    vecs[6]  = '{8'h2A, 1'b1, 4'b1011, 1'b1, 1'b0, 3'd7}; // top bit, corrected
    vecs[7]  = '{8'h2A, 1'b0, 4'b0011, 1'b1, 1'b0, 3'd7}; // top bit, raw
    vecs[8]  = '{8'h2B, 1'b1, 4'b0011, 1'b0, 1'b1, 3'd0}; // bits 7 and 0
    vecs[9]  = '{8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0}; // all-zero clean
    vecs[10] = '{8'hFF, 1'b1, 4'b1111, 1'b0, 1'b0, 3'd0}; // all-one clean
    vecs[11] = '{8'hBF, 1'b1, 4'b1111, 1'b1, 1'b0, 3'd6}; // bit 6, corrected

    // ---------------- reset state ----------------
    rst = 1'b1;
    palabra_in = 8'h00;
    valid_in = 1'b0;
    en_correccion = 1'b1;
    clr_cnt = 1'b0;
    ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_data_out", {28'd0, data_out}, 32'd0);
    check("rst_err_simple", {31'd0, err_simple}, 32'd0);
    check("rst_err_doble", {31'd0, err_doble}, 32'd0);
    check("rst_pos_error", {29'd0, pos_error}, 32'd0);
    check("rst_cnt_corr", {24'd0, cnt_corr}, 32'd0);
    check("rst_cnt_nocorr", {24'd0, cnt_nocorr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);

    // ---------------- single-word vectors ----------------
    for (int i = 0; i < 12; i++) begin
      palabra_in = vecs[i].word;
      en_correccion = vecs[i].en;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), {31'd0, valid_out}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid_out", i), {31'd0, valid_out}, 32'd1);
      check($sformatf("v%0d_data_out", i), {28'd0, data_out}, {28'd0, vecs[i].d});
      check($sformatf("v%0d_err_simple", i), {31'd0, err_simple}, {31'd0, vecs[i].simple});
      check($sformatf("v%0d_err_doble", i), {31'd0, err_doble}, {31'd0, vecs[i].doble});
      check($sformatf("v%0d_pos_error", i), {29'd0, pos_error}, {29'd0, vecs[i].pos});
      if (vecs[i].simple && exp_corr < 255) exp_corr = exp_corr + 1;
      if (vecs[i].doble && exp_nocorr < 255) exp_nocorr = exp_nocorr + 1;
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", i), {31'd0, valid_out}, 32'd0);
      check($sformatf("v%0d_cnt_corr", i), {24'd0, cnt_corr}, exp_corr);
      check($sformatf("v%0d_cnt_nocorr", i), {24'd0, cnt_nocorr}, exp_nocorr);
    end

    // ---------------- backpressure ----------------
    en_correccion = 1'b1;
    ready_out = 1'b1;
    palabra_in = 8'hAA;
    valid_in = 1'b1;
    @(negedge clk);
    palabra_in = 8'h8A;
    @(negedge clk);
    palabra_in = 8'h82;
    ready_out = 1'b0;
    #1;
    check("bp_first_valid", {31'd0, valid_out}, 32'd1);
    check("bp_first_data", {28'd0, data_out}, 32'hB);
    check("bp_ready_in_low", {31'd0, ready_in}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_stall%0d_valid", c), {31'd0, valid_out}, 32'd1);
      check($sformatf("bp_stall%0d_data", c), {28'd0, data_out}, 32'hB);
      check($sformatf("bp_stall%0d_ready_in", c), {31'd0, ready_in}, 32'd0);
    end
    ready_out = 1'b1;
    rx_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) valid_in = 1'b0;
      if (valid_out) begin
        if (rx_n < 3) begin
          rx_d[rx_n] = data_out;
          rx_s[rx_n] = err_simple;
          rx_dd[rx_n] = err_doble;
        end
        rx_n = rx_n + 1;
      end
      @(negedge clk);
    end
    check("bp_word_count", rx_n, 32'd3);
    if (rx_n >= 3) begin
      check("bp_w0_data", {28'd0, rx_d[0]}, 32'hB);
      check("bp_w0_flags", {30'd0, rx_s[0], rx_dd[0]}, 32'd0);
      check("bp_w1_data", {28'd0, rx_d[1]}, 32'hB);
      check("bp_w1_flags", {30'd0, rx_s[1], rx_dd[1]}, 32'd2);
      check("bp_w2_data", {28'd0, rx_d[2]}, 32'h8);
      check("bp_w2_flags", {30'd0, rx_s[2], rx_dd[2]}, 32'd1);
    end
    exp_corr = exp_corr + 1;
    exp_nocorr = exp_nocorr + 1;
    check("bp_cnt_corr", {24'd0, cnt_corr}, exp_corr);
    check("bp_cnt_nocorr", {24'd0, cnt_nocorr}, exp_nocorr);

    // ---------------- clear, saturation ----------------
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_cnt_corr", {24'd0, cnt_corr}, 32'd0);
    check("clr_cnt_nocorr", {24'd0, cnt_nocorr}, 32'd0);
    check("clr_sat_cnt_corr", {30'd0, sat_cnt_corr}, 32'd0);
    palabra_in = 8'h8A;
    valid_in = 1'b1;
    repeat (5) @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_cnt_corr_stops", {30'd0, sat_cnt_corr}, 32'd3);
    check("sat_cnt_nocorr", {30'd0, sat_cnt_nocorr}, 32'd0);
    check("main_cnt_corr_five", {24'd0, cnt_corr}, 32'd5);

    // clr_cnt on the same edge as a counted handshake
    palabra_in = 8'h8A;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    check("clr_hs_valid", {31'd0, valid_out}, 32'd1);
    check("clr_hs_simple", {31'd0, err_simple}, 32'd1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_hs_cnt_corr", {24'd0, cnt_corr}, 32'd0);
    check("clr_hs_sat_cnt_corr", {30'd0, sat_cnt_corr}, 32'd0);
    @(negedge clk);
    check("clr_hs_cnt_corr_after", {24'd0, cnt_corr}, 32'd0);

    // ---------------- reset with two words in flight ----------------
    ready_out = 1'b0;
    palabra_in = 8'hAA;
    valid_in = 1'b1;
    @(negedge clk);
    palabra_in = 8'h8A;
    @(negedge clk);
    valid_in = 1'b0;
    check("mid_pre_valid", {31'd0, valid_out}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("mid_rst_data_out", {28'd0, data_out}, 32'd0);
    check("mid_rst_flags", {28'd0, err_simple, err_doble, 2'd0} | {29'd0, pos_error}, 32'd0);
    check("mid_rst_ready_in", {31'd0, ready_in}, 32'd1);
    rst = 1'b0;
    ready_out = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_out) seen = seen + 1;
    end
    check("mid_rst_no_ghost_words", seen, 32'd0);
    check("mid_rst_cnt_corr", {24'd0, cnt_corr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
